data_sampling_mv: RTL

Parametrised oversampling data sampler for the UART receiver. It synchronises the raw serial line and samples it around the mid-point of each bit period, using a runtime-selectable prescale. In triple mode it takes three samples and resolves the bit by majority vote. Each resolved bit is delivered with a one-cycle valid pulse and a noise flag, for consumption by the deserialiser, start-check and parity-check blocks.

---
 rtl/data_sampling_mv.sv | 121 ++++++++++++
 1 files changed

// File: rtl/data_sampling_mv.sv
// UART receive oversampling sampler: synchronises rx_in, captures it around the
// bit mid-point (single sample or 3-sample majority vote) and pulses sample_valid.
module data_sampling_mv #(
  parameter int PRESCALE_W  = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic                  data_sample_en,
  input  logic                  vote_mode,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  noise_err
);

  typedef enum logic [1:0] {IDLE, S0, S1, DONE} cap_state_e;

  logic rx_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign rx_s = rx_in;
    end else begin : g_sync
      // Resets to all ones so the idle line never looks like a start bit.
      logic [SYNC_STAGES-1:0] sync_q, sync_d;
      always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = rx_in;
      end
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '1;
        else      sync_q <= sync_d;
      end
      assign rx_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  cap_state_e            state_q, state_d;
  logic [2:0]            samp_q, samp_d;
  logic                  sampled_bit_q, sampled_bit_d;
  logic                  sample_valid_q, sample_valid_d;
  logic                  noise_err_q, noise_err_d;
  logic                  vote_mode_q, vote_mode_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;

  logic [PRESCALE_W-1:0] mid, mid_m1, mid_p1;
  logic                  legal, cfg_chg, maj;

  assign mid     = prescale >> 1;
  assign mid_m1  = mid - PRESCALE_W'(1);
  assign mid_p1  = mid + PRESCALE_W'(1);
  assign legal   = !prescale[0] && (prescale >= PRESCALE_W'(4));
  assign cfg_chg = (vote_mode != vote_mode_q) || (prescale != prescale_q);
  assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

  always_comb begin
    state_d        = IDLE;
    samp_d         = '0;
    sampled_bit_d  = sampled_bit_q;
    noise_err_d    = noise_err_q;
    sample_valid_d = 1'b0;
    vote_mode_d    = vote_mode;
    prescale_d     = prescale;
    // DONE is the output cycle; it always drops back to IDLE without capturing,
    // so sample_valid can never pulse on back-to-back cycles.
    if (state_q == DONE || !legal || cfg_chg || !data_sample_en) begin
      state_d = IDLE;
    end else if (!vote_mode) begin
      if (edge_cnt == mid) begin
        state_d        = DONE;
        samp_d         = {3{rx_s}};
        sampled_bit_d  = rx_s;
        noise_err_d    = 1'b0;
        sample_valid_d = 1'b1;
      end
    end else begin
      if (state_q == S0 && edge_cnt == mid) begin
        state_d = S1;
        samp_d  = {1'b0, rx_s, samp_q[0]};
      end else if (state_q == S1 && edge_cnt == mid_p1) begin
        state_d        = DONE;
        samp_d         = {rx_s, samp_q[1:0]};
        sampled_bit_d  = maj;
        noise_err_d    = !((samp_q[0] == samp_q[1]) && (samp_q[1] == rx_s));
        sample_valid_d = 1'b1;
      end else if (edge_cnt == mid_m1) begin
        // Also covers an out-of-order count that lands on mid-1: fresh start.
        state_d = S0;
        samp_d  = {2'b00, rx_s};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      samp_q         <= '0;
      sampled_bit_q  <= 1'b0;
      sample_valid_q <= 1'b0;
      noise_err_q    <= 1'b0;
      vote_mode_q    <= 1'b0;
      prescale_q     <= '0;
    end else begin
      state_q        <= state_d;
      samp_q         <= samp_d;
      sampled_bit_q  <= sampled_bit_d;
      sample_valid_q <= sample_valid_d;
      noise_err_q    <= noise_err_d;
      vote_mode_q    <= vote_mode_d;
      prescale_q     <= prescale_d;
    end
  end

  assign sampled_bit  = sampled_bit_q;
  assign sample_valid = sample_valid_q;
  assign noise_err    = noise_err_q;

endmodule
